// File: rtl/zombie_pkg.sv
// rtl/zombie_pkg.sv - shared state encodings, zombie types and rand-to-type mapping
package zombie_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } game_state_e;

  localparam logic [1:0] TYPE_NONE = 2'd0;
  localparam logic [1:0] TYPE_M1   = 2'd1;
  localparam logic [1:0] TYPE_M2   = 2'd2;
  localparam logic [1:0] TYPE_M3   = 2'd3;

  // (r mod 3) + 1, so the empty type is never produced
  function automatic logic [1:0] rand_to_type(input logic [2:0] r);
    case (r)
      3'd0, 3'd3, 3'd6: rand_to_type = TYPE_M1;
      3'd1, 3'd4, 3'd7: rand_to_type = TYPE_M2;
      default:          rand_to_type = TYPE_M3;
    endcase
  endfunction

endpackage

// File: rtl/zombie_game_ctrl.sv
// rtl/zombie_game_ctrl.sv - game FSM: queue fill, punch judging, bite timer, score and lives
module zombie_game_ctrl
  import zombie_pkg::*;
#(
  parameter int SLOTS      = 6,
  parameter int TYPE_W     = 2,
  parameter int BITE_TICKS = 8,
  parameter int LIVES      = 3,
  parameter int SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic [2:0]         rand_num,
  input  logic [2:0]         btn_pulse,
  input  logic [TYPE_W-1:0]  front_type,
  output logic               shift,
  output logic [TYPE_W-1:0]  fill_type,
  output logic               clear,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               gameover,
  output logic [1:0]         state
);

  localparam int BT_W = (BITE_TICKS > 1) ? $clog2(BITE_TICKS) : 1;

  game_state_e        state_q, state_n;
  logic [2:0]         setup_cnt_q, setup_cnt_n;
  logic [BT_W-1:0]    bite_q, bite_n;
  logic               lockout_q, lockout_n;
  logic               shift_n, clear_n, gameover_n;
  logic [TYPE_W-1:0]  fill_n;
  logic [SCORE_W-1:0] score_n;
  logic [1:0]         lives_n;

  logic               press_ok, hit, miss, bite;
  logic [TYPE_W-1:0]  btn_type;
  logic [TYPE_W-1:0]  rand_type;
  logic [1:0]         loss;

  assign state     = state_q;
  assign rand_type = TYPE_W'(rand_to_type(rand_num));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift       <= 1'b0;
      fill_type   <= '0;
      clear       <= 1'b0;
      score       <= '0;
      lives       <= 2'(LIVES);
      gameover    <= 1'b0;
      setup_cnt_q <= '0;
      bite_q      <= '0;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      shift       <= shift_n;
      fill_type   <= fill_n;
      clear       <= clear_n;
      score       <= score_n;
      lives       <= lives_n;
      gameover    <= gameover_n;
      setup_cnt_q <= setup_cnt_n;
      bite_q      <= bite_n;
      lockout_q   <= lockout_n;
    end
  end

  always_comb begin
    btn_type = TYPE_W'(TYPE_NONE);
    case (btn_pulse)
      3'b001:  btn_type = TYPE_W'(TYPE_M1);
      3'b010:  btn_type = TYPE_W'(TYPE_M2);
      3'b100:  btn_type = TYPE_W'(TYPE_M3);
      default: btn_type = TYPE_W'(TYPE_NONE);
    endcase
    // Non-one-hot presses decode to TYPE_NONE and are dropped here
    press_ok = (state_q == PLAY) && !lockout_q && (btn_type != TYPE_W'(TYPE_NONE));
    hit      = press_ok && (btn_type == front_type);
    miss     = press_ok && !hit;
    bite     = (state_q == PLAY) && !hit && tick && (bite_q == BT_W'(BITE_TICKS - 1));
    loss     = {1'b0, miss} + {1'b0, bite};
  end

  always_comb begin
    state_n     = state_q;
    shift_n     = 1'b0;
    fill_n      = '0;
    clear_n     = 1'b0;
    score_n     = score;
    lives_n     = lives;
    setup_cnt_n = setup_cnt_q;
    bite_n      = bite_q;
    lockout_n   = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_n     = SETUP;
          clear_n     = 1'b1;
          score_n     = '0;
          lives_n     = 2'(LIVES);
          setup_cnt_n = '0;
        end
      end
      SETUP: begin
        shift_n     = 1'b1;
        fill_n      = rand_type;
        setup_cnt_n = setup_cnt_q + 3'd1;
        if (setup_cnt_q == 3'(SLOTS - 1)) begin
          state_n   = PLAY;
          bite_n    = '0;
          lockout_n = 1'b1;
        end
      end
      PLAY: begin
        if (hit || bite)
          bite_n = '0;
        else if (tick)
          bite_n = bite_q + BT_W'(1);
        if (hit && score != '1)
          score_n = score + SCORE_W'(1);
        lives_n = (lives > loss) ? lives - loss : 2'd0;
        if (lives_n == 2'd0) begin
          state_n = OVER;
          clear_n = 1'b1;
        end else if (hit || bite) begin
          // front_type lags the shift by a cycle, so block presses until it settles
          shift_n   = 1'b1;
          fill_n    = rand_type;
          lockout_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    gameover_n = (state_n == OVER);
  end

endmodule

// File: doc/zombie_game_ctrl.md
Name: zombie_game_ctrl

Overview:
Game sequencer for the punch-zombie LED-matrix game. It owns the game FSM (IDLE/SETUP/PLAY/OVER), fills the 6-slot zombie queue at start, and judges button punches against the front zombie. It also times zombie bites, keeps score and lives, and issues shift/clear strobes and the new-zombie type to the matrix picture datapath. It sits between the button debouncers/random source and the matrix generator.

Parameters:
SLOTS, 6, number of zombie queue slots filled during SETUP
TYPE_W, 2, zombie type width; 0 = empty, 1..3 = monster types matching btn1..btn3
BITE_TICKS, 8, tick pulses the front zombie survives before it bites
LIVES, 3, starting lives (1..3)
SCORE_W, 8, score counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (0 = reset)
start  in  1  level; starts a game from IDLE or OVER
tick  in  1  one-cycle game-rate pulse from the divider
rand_num  in  3  free-running random value
btn_pulse  in  3  one-cycle debounced presses; bit0 = btn1, bit1 = btn2, bit2 = btn3
front_type  in  TYPE_W  type of zombie in front slot (slot 0) of datapath
shift  out  1  one-cycle strobe: datapath advances queue, inserts fill_type at tail
fill_type  out  TYPE_W  type inserted on shift; valid while shift = 1
clear  out  1  one-cycle strobe: datapath wipes all slots
score  out  SCORE_W  hits this game
lives  out  2  remaining lives
gameover  out  1  high in OVER
state  out  2  FSM state for display/debug

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (port rst, sampled on posedge clk, 0 = reset). All outputs are registered.
- Reset values: state = IDLE, shift = 0, fill_type = 0, clear = 0, score = 0, lives = LIVES, gameover = 0, setup_cnt = 0, bite_timer = 0, lockout = 0.
- Type mapping: type = (rand_num mod 3) + 1, giving 0→1, 1→2, 2→3, 3→1, 4→2, 5→3, 6→1, 7→2. Type 0 is never generated.
- State encoding: IDLE = 0, SETUP = 1, PLAY = 2, OVER = 3.
- IDLE:
  - All strobes are 0.
  - If start = 1, next state is SETUP, clear = 1 for that one cycle, score = 0, lives = LIVES, setup_cnt = 0.
- SETUP:
  - Every cycle: shift = 1, fill_type = map(rand_num), setup_cnt increments.
  - After exactly SLOTS shift cycles, the next state is PLAY with bite_timer = 0 and lockout = 1.
  - Buttons and tick are ignored.
- PLAY, judged each cycle while lockout = 0:
  - Valid press: btn_pulse is one-hot. A press with 0 or ≥2 bits set is ignored entirely.
  - Hit: bit index + 1 equals front_type. Next cycle: shift = 1, fill_type = map(rand_num), score + 1 (saturates at all-ones), bite_timer = 0.
  - Miss: front_type = 0 or a different type. Lives - 1, no shift.
  - tick = 1 with no hit: bite_timer + 1. When bite_timer = BITE_TICKS - 1 and tick = 1, a bite occurs: lives - 1, shift = 1 (bitten zombie leaves), bite_timer = 0.
  - Hit and tick in the same cycle: hit wins, bite_timer = 0, the tick is dropped.
  - Miss and bite in the same cycle: lives - 2, floored at 0.
  - lockout is set for the one cycle after any shift, because the datapath updates front_type one cycle later. During lockout, buttons are ignored; tick still counts.
  - If the resulting lives = 0, the next state is OVER. No further shifts are issued.
- OVER:
  - gameover = 1. clear = 1 on the entry cycle only.
  - If start = 1, go to SETUP with the same initialisation as from IDLE; gameover drops with the state change.
- Reset mid-game: asserting rst in any state returns to the reset values on the next edge. A SETUP sequence cut off by reset must not finish.
- Widths: lives compares and decrements in 2 bits with no wrap below 0. setup_cnt is 3 bits.

Decomposition:
- zombie_pkg holds:
  - the state encodings IDLE/SETUP/PLAY/OVER
  - TYPE_NONE = 0, TYPE_M1 = 1, TYPE_M2 = 2, TYPE_M3 = 3
  - the rand-to-type function, shared with the matrix generator
- No sub-module is required; the bite timer stays inline.

Test Plan:
- rst = 0 for 2 cycles, then start = 1 → clear pulses once, then exactly 6 consecutive shift pulses; with rand_num = 4 held, fill_type = 2 on each; state = PLAY.
- PLAY, front_type = 3, btn_pulse = 3'b100 → shift = 1 next cycle, score 0→1; a btn_pulse = 3'b100 on the following (lockout) cycle is ignored, score stays 1.
- front_type = 1, btn_pulse = 3'b010 → lives 3→2, no shift; btn_pulse = 3'b011 → no change at all.
- No presses, 8 tick pulses → exactly one bite on the 8th tick: lives - 1, one shift, bite_timer back to 0.
- Correct hit and the 8th tick in the same cycle → score + 1, lives unchanged, exactly one shift.
- Three misses → lives 0, state = OVER, gameover = 1, clear pulses once; start → SETUP with score = 0 and lives = 3. rst = 0 asserted in the middle of SETUP → state = IDLE with no further shifts.
